sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter N, default 4: number of switch channels, one per bit of the HPS switch PIO input.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles required to accept a change; legal range 2 to 2^24.
REQ-003 clk_clk  input  1: the single system clock, the same clock that feeds the HPS system clk_clk.
REQ-004 reset_reset  input  1: reset, synchronous and active-high.
REQ-005 sw_raw  input  N: asynchronous, bouncing board switch levels.
REQ-006 sw_stable  output  N: debounced levels, wired directly to sw_external_connection_export.
REQ-007 sw_change  output  N: one-cycle pulse per bit when that bit's sw_stable changes.
REQ-008 irq_clear  input  1: clears the sticky change events (see REQ-024).
REQ-009 sw_irq  output  1: level interrupt request toward the HPS (see REQ-024).

Function
REQ-010 Each sw_raw bit SHALL pass through a 2-flop synchronizer; the second flop output is sync[i].
REQ-011 Each channel SHALL run an independent two-state FSM with states IDLE (sync[i]==sw_stable[i]) and PENDING (sync[i]!=sw_stable[i]).
- Each channel also has a counter cnt[i] of width clog2(DEBOUNCE_CYCLES).
REQ-012 In IDLE, cnt[i] SHALL hold 0; the first cycle sync[i]!=sw_stable[i] moves the channel to PENDING with cnt[i]=1.
REQ-013 In PENDING with the mismatch persisting and cnt[i]<DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014 In PENDING with cnt[i]==DEBOUNCE_CYCLES-1 and the mismatch persisting, at the next edge the channel SHALL:
- set sw_stable[i] to sync[i];
- pulse sw_change[i] high for exactly one cycle;
- clear cnt[i] to 0 and return to IDLE.
REQ-015 In PENDING, if sync[i] returns to equal sw_stable[i], the channel SHALL return to IDLE with cnt[i]=0 and no change pulse; a glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
REQ-016 Latency SHALL be 2 + DEBOUNCE_CYCLES clock edges from the first edge sampling the new sw_raw level to sw_stable updating, provided sw_raw is steady throughout.
REQ-017 sw_stable and sw_change SHALL be registered outputs with no combinational path from sw_raw.
REQ-018 Channels SHALL be fully independent; simultaneous changes on several bits produce simultaneous sw_change pulses.
REQ-019 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While reset_reset is high at a clock edge, the following SHALL be cleared to 0: synchronizer flops, sw_stable, sw_change, all cnt, all FSMs (to IDLE), and the sticky event register with sw_irq.
REQ-021 Reset asserted mid-PENDING SHALL abort the pending change with no sw_change pulse.
REQ-022 After reset release with a sw_raw bit held at 1, that bit SHALL follow REQ-016: sw_stable goes to 1 with one sw_change pulse.
REQ-023 The block SHALL use no asynchronous reset and no second clock.

Configuration
REQ-024 With macro SW_CHANGE_IRQ_EN defined:
- an N-bit sticky register sw_event SHALL set bit i on sw_change[i];
- irq_clear high SHALL clear all bits of sw_event, with a set in the same cycle taking priority (that bit stays 1);
- sw_irq SHALL be registered OR-reduce of sw_event, asserting one cycle after the event bit sets.
REQ-025 Without SW_CHANGE_IRQ_EN:
- no sticky register is built;
- sw_irq SHALL be tied to 0 and irq_clear ignored;
- ports remain present so the top level is unchanged.

Verification (bench uses DEBOUNCE_CYCLES=8, N=4)
REQ-026 Reset, then sw_raw 0000->0001 held -> sw_stable==0001 exactly 10 edges later, sw_change==0001 for one cycle, sw_irq==1 one cycle later (macro on).
REQ-027 sw_raw bit1 toggled high for 5 cycles then low -> sw_stable and sw_change unchanged, cnt returns to 0.
REQ-028 Bounce pattern on bit2 (1,0,1,1,0 then held 1) -> single sw_change[2] pulse, 10 edges after the final rising sample.
REQ-029 sw_raw 0000->1111 in one cycle -> all four sw_change bits pulse in the same cycle, sw_stable==1111.
REQ-030 reset_reset asserted 4 cycles into a pending change on bit3 -> all outputs 0, no pulse; on release with sw_raw[3]=1 -> sw_stable[3]==1 after 10 edges.
REQ-031 irq_clear coincident with a new sw_change[0] (macro on) -> sw_event[0] stays 1, sw_irq stays 1; macro off -> sw_irq stays 0 throughout.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: per-channel switch debouncer with optional change interrupt.
//   clk_clk      system clock
//   reset_reset  synchronous active-high reset
//   sw_raw       asynchronous, bouncing switch levels (N bits)
//   sw_stable    debounced levels (registered)
//   sw_change    one-cycle pulse per bit when sw_stable changes (registered)
//   irq_clear    clears the sticky change events
//   sw_irq       level interrupt request (registered)
// Optional feature macro: SW_CHANGE_IRQ_EN builds the sticky event register
// and drives sw_irq; without it sw_irq is tied low and irq_clear is ignored.
module sw_debounce #(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_stable,
  output logic [N-1:0] sw_change,
  input  logic         irq_clear,
  output logic         sw_irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  logic [N-1:0]     sync1_q, sync2_q;
  state_e           state_q [N];
  state_e           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];
  logic [N-1:0]     stable_q, stable_d;
  logic [N-1:0]     change_q, change_d;

  // Per-channel debounce FSM; a mismatch must persist DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    change_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = IDLE;
      cnt_d[i]   = '0;
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i] != stable_q[i]) begin
            state_d[i] = PENDING;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        PENDING: begin
          // Mismatch gone: fall back to IDLE with cnt 0 (the defaults).
          if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              stable_d[i] = sync2_q[i];
              change_d[i] = 1'b1;
            end else begin
              state_d[i] = PENDING;
              cnt_d[i]   = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      change_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q  <= sw_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      change_q <= change_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign sw_stable = stable_q;
  assign sw_change = change_q;

`ifdef SW_CHANGE_IRQ_EN
  logic [N-1:0] sw_event_q, sw_event_d;
  logic         irq_q;

  // Sets win over clear; setting on both the upcoming and the visible pulse
  // keeps an event that coincides with irq_clear in either cycle.
  always_comb begin
    sw_event_d = (sw_event_q & ~{N{irq_clear}}) | change_d | change_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sw_event_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sw_event_q <= sw_event_d;
      irq_q      <= |sw_event_q;
    end
  end

  assign sw_irq = irq_q;
`else
  logic unused_irq_clear;
  assign unused_irq_clear = irq_clear;
  assign sw_irq           = 1'b0;
`endif

endmodule
